// File: rtl/cva6_lsu_mem_arbiter.sv
// cva6_lsu_mem_arbiter
// Shares one data-memory port between the LSU load unit and the store drain
// path. Loads normally win, but a waiting store is forced through after
// STARVE_LIMIT back-to-back load grants. Every accepted request is tracked in
// an in-order FIFO so each memory response can be routed back to its owner.
// A load whose word address matches an in-flight store is held off until that
// store has responded (read-after-write hazard).
//
// Optional feature: define CVA6_LSU_ARB_PERF_EN to add three 32-bit
// performance counters (load grants, store grants, hazard stall cycles).
//
// Handshake rules (all channels):
//   - ld_req_i / st_req_i are held high, with a stable address, until the
//     matching ld_gnt_o / st_gnt_o is seen; a grant completes the request.
//   - mem_req_o is offered to memory; a request is accepted in any cycle
//     where mem_req_o && mem_gnt_i. Once offered and not accepted, the same
//     owner and address are presented until acceptance (lock).
//   - mem_rvalid_i returns exactly one response per accepted request, in
//     acceptance order; it is routed to ld_rvalid_o or st_rvalid_o in the
//     same cycle.
// dbg_locked_o exposes the lock FSM state (1 = request held for memory).
module cva6_lsu_mem_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 3,
  parameter int ADDR_W          = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic              ld_gnt_o,
  output logic              ld_rvalid_o,
  input  logic              st_req_i,
  input  logic [ADDR_W-1:0] st_addr_i,
  output logic              st_gnt_o,
  output logic              st_rvalid_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  output logic              dbg_locked_o
`ifdef CVA6_LSU_ARB_PERF_EN
  ,
  output logic [31:0]       perf_ld_grants_o,
  output logic [31:0]       perf_st_grants_o,
  output logic [31:0]       perf_hazard_stalls_o
`endif
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SC_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int WA_W  = ADDR_W - 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  // Lock FSM state and the saved selection
  lock_state_e       state_q, state_d;
  logic              lock_we_q, lock_we_d;
  logic [ADDR_W-1:0] lock_addr_q, lock_addr_d;

  // Outstanding FIFO: owner bit and word address per entry
  logic              fifo_we_q   [MAX_OUTSTANDING];
  logic [WA_W-1:0]   fifo_addr_q [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] fifo_vld_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic [SC_W-1:0]   starve_q;

  logic fifo_full;
  logic ld_hazard;
  logic ld_eligible;
  logic starve_at_limit;
  logic sel_ld, sel_st;
  logic grant;
  logic push, pop;

  assign fifo_full       = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign ld_eligible     = ld_req_i && !ld_hazard;
  assign starve_at_limit = (starve_q == SC_W'(STARVE_LIMIT));
  assign dbg_locked_o    = (state_q == ST_LOCKED);

  // RAW hazard: any tracked store to the same word as the pending load
  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (fifo_vld_q[i] && fifo_we_q[i] &&
          (fifo_addr_q[i] == ld_addr_i[ADDR_W-1:2])) begin
        ld_hazard = 1'b1;
      end
    end
  end

  // Lock FSM next state plus requester selection and memory request outputs
  always_comb begin
    state_d     = state_q;
    lock_we_d   = lock_we_q;
    lock_addr_d = lock_addr_q;
    sel_ld      = 1'b0;
    sel_st      = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    if (!rst_i) begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_full) begin
            if (ld_eligible && !(st_req_i && starve_at_limit)) begin
              sel_ld = 1'b1;
            end else if (st_req_i) begin
              sel_st = 1'b1;
            end
          end
          mem_req_o  = sel_ld || sel_st;
          mem_we_o   = sel_st;
          if (sel_st) begin
            mem_addr_o = st_addr_i;
          end else if (sel_ld) begin
            mem_addr_o = ld_addr_i;
          end
          // Memory stalled: freeze this selection until it is accepted
          if ((sel_ld || sel_st) && !mem_gnt_i) begin
            state_d     = ST_LOCKED;
            lock_we_d   = sel_st;
            lock_addr_d = sel_st ? st_addr_i : ld_addr_i;
          end
        end
        ST_LOCKED: begin
          sel_ld     = !lock_we_q;
          sel_st     = lock_we_q;
          mem_req_o  = 1'b1;
          mem_we_o   = lock_we_q;
          mem_addr_o = lock_addr_q;
          if (mem_gnt_i) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign grant    = mem_req_o && mem_gnt_i;
  assign ld_gnt_o = grant && sel_ld;
  assign st_gnt_o = grant && sel_st;

  // Responses pop the FIFO head; a response with nothing tracked is dropped
  assign push        = grant;
  assign pop         = mem_rvalid_i && (count_q != '0) && !rst_i;
  assign ld_rvalid_o = pop && !fifo_we_q[rd_ptr_q];
  assign st_rvalid_o = pop &&  fifo_we_q[rd_ptr_q];

  // Lock FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      lock_we_q   <= 1'b0;
      lock_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      lock_we_q   <= lock_we_d;
      lock_addr_q <= lock_addr_d;
    end
  end

  // FIFO pointers, occupancy and per-entry valid bits
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fifo_vld_q <= '0;
    end else begin
      if (pop) begin
        rd_ptr_q             <= rd_ptr_q + PTR_W'(1);
        fifo_vld_q[rd_ptr_q] <= 1'b0;
      end
      if (push) begin
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
        fifo_vld_q[wr_ptr_q] <= 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // FIFO payload; only meaningful where the valid bit is set
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_we_q[wr_ptr_q]   <= mem_we_o;
      fifo_addr_q[wr_ptr_q] <= mem_addr_o[ADDR_W-1:2];
    end
  end

  // Starvation guard: counts load grants taken while a store is waiting
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else if (st_gnt_o || !st_req_i) begin
      starve_q <= '0;
    end else if (ld_gnt_o && !starve_at_limit) begin
      starve_q <= starve_q + SC_W'(1);
    end
  end

`ifdef CVA6_LSU_ARB_PERF_EN
  // Free-running performance counters, wrapping at 2^32
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_ld_grants_o     <= '0;
      perf_st_grants_o     <= '0;
      perf_hazard_stalls_o <= '0;
    end else begin
      if (ld_gnt_o) begin
        perf_ld_grants_o <= perf_ld_grants_o + 32'd1;
      end
      if (st_gnt_o) begin
        perf_st_grants_o <= perf_st_grants_o + 32'd1;
      end
      if (ld_req_i && ld_hazard) begin
        perf_hazard_stalls_o <= perf_hazard_stalls_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cva6_lsu_mem_arbiter.sv
// Testbench for cva6_lsu_mem_arbiter: directed scenarios followed by a
// randomized phase, all checked cycle by cycle against a queue-based model.
module tb_cva6_lsu_mem_arbiter;

  localparam int MAXO   = 4;
  localparam int STARVE = 3;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        ld_req, st_req, mem_gnt, mem_rvalid;
  logic [31:0] ld_addr, st_addr;
  logic        ld_gnt, ld_rvalid, st_gnt, st_rvalid;
  logic        mem_req, mem_we, dbg_locked;
  logic [31:0] mem_addr;
`ifdef CVA6_LSU_ARB_PERF_EN
  logic [31:0] perf_ld, perf_st, perf_hz;
`endif

  cva6_lsu_mem_arbiter #(
    .MAX_OUTSTANDING(MAXO),
    .STARVE_LIMIT(STARVE),
    .ADDR_W(32)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .ld_req_i(ld_req),
    .ld_addr_i(ld_addr),
    .ld_gnt_o(ld_gnt),
    .ld_rvalid_o(ld_rvalid),
    .st_req_i(st_req),
    .st_addr_i(st_addr),
    .st_gnt_o(st_gnt),
    .st_rvalid_o(st_rvalid),
    .mem_req_o(mem_req),
    .mem_addr_o(mem_addr),
    .mem_we_o(mem_we),
    .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid),
    .dbg_locked_o(dbg_locked)
`ifdef CVA6_LSU_ARB_PERF_EN
    ,
    .perf_ld_grants_o(perf_ld),
    .perf_st_grants_o(perf_st),
    .perf_hazard_stalls_o(perf_hz)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference model: outstanding transactions as {we, addr}, head = oldest
  logic [32:0] exp_q[$];
  bit          m_locked;
  bit          m_lock_we;
  logic [31:0] m_lock_addr;
  int          m_starve;
  logic [31:0] m_ld_g, m_st_g, m_hz;

  // Last observed DUT outputs, for scenario-specific checks
  logic        obs_ld_gnt, obs_st_gnt, obs_ld_rv, obs_st_rv, obs_req, obs_we;
  logic [31:0] obs_addr;

  task automatic model_reset();
    exp_q.delete();
    m_locked    = 0;
    m_lock_we   = 0;
    m_lock_addr = '0;
    m_starve    = 0;
    m_ld_g      = '0;
    m_st_g      = '0;
    m_hz        = '0;
  endtask

  // Driver + scoreboard for one clock cycle
  task automatic step(input logic l, input logic [31:0] la, input logic s,
                      input logic [31:0] sa, input logic g, input logic rv);
    bit          e_req, e_we, hz, full, pop;
    logic [31:0] e_addr;
    @(negedge clk);
    ld_req = l; ld_addr = la; st_req = s; st_addr = sa;
    mem_gnt = g; mem_rvalid = rv;
    #1;
    full = (exp_q.size() >= MAXO);
    hz = 0;
    foreach (exp_q[i]) if (exp_q[i][32] && exp_q[i][31:2] == la[31:2]) hz = 1;
    e_req = 0; e_we = 0; e_addr = '0;
    if (m_locked) begin
      e_req = 1; e_we = m_lock_we; e_addr = m_lock_addr;
    end else if (!full) begin
      if (l && !hz && !(s && m_starve == STARVE)) begin
        e_req = 1; e_addr = la;
      end else if (s) begin
        e_req = 1; e_we = 1; e_addr = sa;
      end
    end
    pop = rv && (exp_q.size() > 0);
    check("mem_req", mem_req, e_req);
    check("mem_we", mem_we, e_we);
    check("mem_addr", mem_addr, e_addr);
    check("ld_gnt", ld_gnt, e_req && g && !e_we);
    check("st_gnt", st_gnt, e_req && g && e_we);
    check("ld_rvalid", ld_rvalid, pop && !exp_q[0][32]);
    check("st_rvalid", st_rvalid, pop && exp_q[0][32]);
    check("dbg_locked", dbg_locked, m_locked);
    obs_ld_gnt = ld_gnt; obs_st_gnt = st_gnt; obs_ld_rv = ld_rvalid;
    obs_st_rv = st_rvalid; obs_req = mem_req; obs_we = mem_we; obs_addr = mem_addr;
    // advance model to the state after the coming clock edge
    if (l && hz) m_hz++;
    if (pop) void'(exp_q.pop_front());
    if (e_req && g) begin
      exp_q.push_back({e_we, e_addr});
      if (e_we) m_st_g++; else m_ld_g++;
    end
    if ((e_req && g && e_we) || !s) m_starve = 0;
    else if (e_req && g && !e_we && m_starve < STARVE) m_starve++;
    if (e_req && !g) begin
      m_locked = 1; m_lock_we = e_we; m_lock_addr = e_addr;
    end else if (e_req && g) begin
      m_locked = 0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 16; i++) begin
      if (exp_q.size() == 0) break;
      step(0, '0, 0, '0, 0, 1);
    end
  endtask

  logic [7:0]  order;
  logic        r_ld, r_st;
  logic [31:0] r_ld_addr, r_st_addr;

  initial begin
    model_reset();
    // Reset state with requests and a response pending at the inputs
    rst = 1; ld_req = 1; ld_addr = 32'h100; st_req = 1; st_addr = 32'h300;
    mem_gnt = 1; mem_rvalid = 1;
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_ld_gnt", ld_gnt, 0);
    check("rst_st_gnt", st_gnt, 0);
    check("rst_ld_rvalid", ld_rvalid, 0);
    check("rst_st_rvalid", st_rvalid, 0);
    repeat (2) @(negedge clk);
    rst = 0; ld_req = 0; st_req = 0; mem_rvalid = 0;

    // Single load, response two cycles later
    step(1, 32'h100, 0, '0, 1, 0);
    check("t1_ld_gnt", obs_ld_gnt, 1);
    check("t1_we", obs_we, 0);
    step(0, '0, 0, '0, 1, 0);
    step(0, '0, 0, '0, 1, 1);
    check("t1_ld_rvalid", obs_ld_rv, 1);
    check("t1_st_rvalid", obs_st_rv, 0);

    // Starvation guard: L,L,L,S,L,L,L,S
    order = '0;
    for (int i = 0; i < 8; i++) begin
      step(1, 32'h100, 1, 32'h300, 1, 1);
      order[i] = obs_st_gnt;
    end
    check("t2_order", order, 8'h88);
    drain();

    // RAW hazard on same word, none on the next word
    step(0, '0, 1, 32'h200, 1, 0);
    check("t3_st_gnt", obs_st_gnt, 1);
    step(1, 32'h203, 0, '0, 1, 0);
    check("t3_blk0", obs_ld_gnt, 0);
    step(1, 32'h203, 0, '0, 1, 0);
    check("t3_blk1", obs_ld_gnt, 0);
    step(1, 32'h203, 0, '0, 1, 1);
    check("t3_blk_pop", obs_ld_gnt, 0);
    check("t3_st_rvalid", obs_st_rv, 1);
    step(1, 32'h203, 0, '0, 1, 0);
    check("t3_release", obs_ld_gnt, 1);
    drain();
    step(0, '0, 1, 32'h200, 1, 0);
    step(1, 32'h204, 0, '0, 1, 0);
    check("t3_other_word", obs_ld_gnt, 1);
    drain();

    // Lock holds a stalled store while a load arrives
    step(0, '0, 1, 32'h340, 0, 0);
    check("t4_we0", obs_we, 1);
    step(1, 32'h100, 1, 32'h340, 0, 0);
    check("t4_we1", obs_we, 1);
    check("t4_addr1", obs_addr, 32'h340);
    step(1, 32'h100, 1, 32'h340, 0, 0);
    check("t4_addr2", obs_addr, 32'h340);
    step(1, 32'h100, 1, 32'h340, 1, 0);
    check("t4_st_gnt", obs_st_gnt, 1);
    step(1, 32'h100, 0, '0, 1, 0);
    check("t4_ld_after", obs_ld_gnt, 1);
    drain();

    // Full FIFO blocks issue, even with a same-cycle pop
    for (int i = 0; i < 4; i++) begin
      step(1, 32'h400 + 32'(i * 4), 0, '0, 1, 0);
      check("t5_fill", obs_ld_gnt, 1);
    end
    step(1, 32'h410, 0, '0, 1, 0);
    check("t5_full", obs_req, 0);
    step(1, 32'h410, 0, '0, 1, 1);
    check("t5_full_pop", obs_req, 0);
    check("t5_pop_rv", obs_ld_rv, 1);
    step(1, 32'h410, 0, '0, 1, 0);
    check("t5_resume", obs_ld_gnt, 1);
    drain();

    // Randomized traffic over a small address window to provoke hazards
    r_ld = 0; r_st = 0; r_ld_addr = '0; r_st_addr = '0;
    for (int c = 0; c < 1500; c++) begin
      if (!r_ld && $urandom_range(0, 1) == 1) begin
        r_ld = 1; r_ld_addr = 32'h200 + 32'($urandom_range(0, 15));
      end
      if (!r_st && $urandom_range(0, 2) == 0) begin
        r_st = 1; r_st_addr = 32'h200 + 32'($urandom_range(0, 15));
      end
      step(r_ld, r_ld_addr, r_st, r_st_addr,
           logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 9) < 4));
      if (obs_ld_gnt) r_ld = 0;
      if (obs_st_gnt) r_st = 0;
    end
`ifdef CVA6_LSU_ARB_PERF_EN
    check("perf_ld", perf_ld, m_ld_g);
    check("perf_st", perf_st, m_st_g);
    check("perf_hz", perf_hz, m_hz);
`endif
    drain();

    // Reset with two transactions in flight, then stale responses
    step(1, 32'h500, 0, '0, 1, 0);
    step(0, '0, 1, 32'h600, 1, 0);
    @(negedge clk);
    rst = 1; ld_req = 1; ld_addr = 32'h700; st_req = 1; st_addr = 32'h800;
    mem_gnt = 1; mem_rvalid = 1;
    #1;
    check("rst2_mem_req", mem_req, 0);
    check("rst2_mem_addr", mem_addr, 0);
    check("rst2_mem_we", mem_we, 0);
    check("rst2_ld_rvalid", ld_rvalid, 0);
    check("rst2_st_rvalid", st_rvalid, 0);
    check("rst2_gnt", {ld_gnt, st_gnt}, 0);
    model_reset();
`ifdef CVA6_LSU_ARB_PERF_EN
    check("rst2_perf", {perf_ld, perf_st, perf_hz}, 0);
`endif
    @(negedge clk);
    rst = 0; ld_req = 0; st_req = 0;
    step(0, '0, 0, '0, 0, 1);
    check("stale_ld_rv", obs_ld_rv, 0);
    step(0, '0, 0, '0, 0, 1);
    check("stale_st_rv", obs_st_rv, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cva6_lsu_mem_arbiter.md
Name: cva6_lsu_mem_arbiter

Overview:
- Shares one data-memory port between the LSU load unit and the store drain path.
- Arbitrates load vs. store requests with a starvation guard.
- Tracks up to MAX_OUTSTANDING in-order transactions and routes each response back to its owner.
- Blocks a load whose word address matches an in-flight store (RAW hazard).

Parameters:
- MAX_OUTSTANDING, 4: depth of the in-order outstanding FIFO; power of two, 2..8.
- STARVE_LIMIT, 3: consecutive load grants, while a store waits, before the store gets priority.
- ADDR_W, 32: address width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- ld_req_i  in  1  load request; held until ld_gnt_o
- ld_addr_i  in  ADDR_W  load address; stable while ld_req_i is high
- ld_gnt_o  out  1  load accepted this cycle
- ld_rvalid_o  out  1  load response
- st_req_i  in  1  store request; held until st_gnt_o
- st_addr_i  in  ADDR_W  store address
- st_gnt_o  out  1  store accepted this cycle
- st_rvalid_o  out  1  store response
- mem_req_o  out  1  memory request
- mem_addr_o  out  ADDR_W  memory address
- mem_we_o  out  1  1 = store, 0 = load
- mem_gnt_i  in  1  memory accepts request
- mem_rvalid_i  in  1  memory response; in order, one per accepted request

Behaviour:
- Reset: all outputs 0, FIFO empty, lock cleared, starvation counter 0. Reset mid-transaction discards all tracked entries.
- Issue condition: FIFO not full (count < MAX_OUTSTANDING), evaluated on registered state. A full FIFO blocks issue even if mem_rvalid_i pops in the same cycle.
- Load eligibility: ld_req_i && no FIFO store entry whose addr[ADDR_W-1:2] equals ld_addr_i[ADDR_W-1:2].
- Selection when unlocked:
  - Eligible load wins, unless st_req_i && starve_cnt == STARVE_LIMIT; then the store wins.
  - Otherwise the store is selected if st_req_i.
- mem_req_o, mem_addr_o and mem_we_o are combinational from the selection.
- Lock: if mem_req_o && !mem_gnt_i, the selection is registered (lock = 1, owner saved). The next cycles must present the same owner and address until a grant. Requesters must not drop a request before its grant.
- Grant: ld_gnt_o / st_gnt_o = mem_req_o && mem_gnt_i && the owner is selected (combinational). On grant:
  - Push {we, addr} to the FIFO.
  - Clear the lock.
- Starvation counter:
  - Increment on a load grant while st_req_i (saturates at STARVE_LIMIT).
  - Clear on a store grant or when !st_req_i.
- Response: mem_rvalid_i pops the FIFO head. ld_rvalid_o = mem_rvalid_i && !head.we; st_rvalid_o = mem_rvalid_i && head.we (combinational, same cycle).
- Push and pop in the same cycle: count unchanged, both performed.
- A store's hazard clears in the cycle after its response pops.
- mem_rvalid_i with an empty FIFO (e.g. after reset): ignored, no rvalid output asserted.
- Pointers wrap modulo MAX_OUTSTANDING; count width is clog2(MAX_OUTSTANDING)+1.

Optional Feature:
- Macro: CVA6_LSU_ARB_PERF_EN
- With the macro defined, three extra output ports:
  - perf_ld_grants_o [31:0]: load grants.
  - perf_st_grants_o [31:0]: store grants.
  - perf_hazard_stalls_o [31:0]: cycles with ld_req_i high, load ineligible due to hazard.
- Counters wrap at 2^32 and reset to 0.
- Without the macro: ports and logic are absent; the core behaviour is identical.

Test Plan:
- Single load 0x100, mem_gnt_i=1, mem_rvalid_i two cycles later -> ld_gnt_o in cycle 0, mem_we_o=0, ld_rvalid_o in cycle 2, st_rvalid_o stays 0.
- ld_req_i and st_req_i held continuously, gnt always 1, STARVE_LIMIT=3 -> grant order L,L,L,S,L,L,L,S.
- Store to 0x200 outstanding, then load to 0x203 -> ld_gnt_o held 0 until the cycle after the store response. A load to 0x204 is granted immediately.
- mem_gnt_i=0 for 3 cycles with a store selected, load arriving in cycle 1 -> mem_addr_o and mem_we_o stay on the store; st_gnt_o fires in cycle 3.
- 4 loads granted, no responses -> the 5th request sees mem_req_o=0. One mem_rvalid_i -> issue resumes the next cycle, and responses route in grant order.
- rst_i asserted with 2 transactions in flight, then stale mem_rvalid_i -> all outputs 0 and no ld_rvalid_o / st_rvalid_o. With CVA6_LSU_ARB_PERF_EN, the counters read 0.
